// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serial UART frame transmitter (start, LSB-first data, optional parity, 1-2 stop bits)
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset; aborts any frame in flight
//   tx_start     start request, accepted only in IDLE
//   din          data word, captured on the accept edge
//   tx_busy      high while a frame is in progress
//   tx_done_tick one-cycle pulse in the first IDLE cycle after the last stop bit
//   tx           registered serial line, idles high
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DBIT = 8,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DBIT + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [DBIT-1:0] sh, sh_n;
  logic par, par_n, tx_n, done_n, tick;
  assign tick = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign tx_busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      par <= 1'b0;
      tx <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      state <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      sh <= sh_n;
      par <= par_n;
      tx <= tx_n;
      tx_done_tick <= done_n;
    end
  always_comb begin
    state_n = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    sh_n = sh;
    par_n = par;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (tx_start) begin
        state_n = START;
        sh_n = din;
        par_n = ^din ^ (PARITY_ODD != 0);
        clk_cnt_n = '0;
      end
    end else begin
      clk_cnt_n = tick ? '0 : clk_cnt + 1'b1;
      if (tick)
        case (state)
          START: begin
            state_n = DATA;
            bit_cnt_n = '0;
          end
          DATA: begin
            sh_n = sh >> 1;
            bit_cnt_n = bit_cnt == BW'(DBIT - 1) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == BW'(DBIT - 1)) state_n = PARITY_EN != 0 ? PARITY : STOP;
          end
          PARITY: state_n = STOP;
          STOP: begin
            bit_cnt_n = bit_cnt == BW'(STOP_BITS - 1) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              state_n = IDLE;
              done_n = 1'b1;
            end
          end
          default: state_n = IDLE;
        endcase
    end
    // line value follows the next state so tx changes on the same edge as the state
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench driving four differently configured transmitters
module tb_uart_tx_frame;
  localparam int C = 4;
  localparam int NI = 4;
  localparam int DB[NI] = '{8, 8, 8, 5};
  localparam int PE[NI] = '{0, 1, 1, 1};
  localparam int PO[NI] = '{0, 0, 1, 1};
  localparam int SB[NI] = '{1, 1, 1, 2};
  logic clk = 1'b0;
  logic [NI-1:0] rst_s, start_s, tx_w, busy_w, done_w;
  logic [7:0] din_s [NI];
  logic [15:0] eb [NI][8];
  int en [NI][8];
  bit eb2b [NI][8];
  int wr [NI], rd [NI];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", nm, g, act, exp, $time);
    end
  endtask
  // expected frame as a bit list: start, data LSB first, optional parity, stop bits
  function automatic logic [15:0] model(input int g, input logic [7:0] d, output int n);
    logic [15:0] b;
    logic [7:0] m;
    int p;
    b = '0;
    m = d & 8'((9'd1 << DB[g]) - 9'd1);
    p = 1;
    for (int i = 0; i < DB[g]; i++) begin
      b[p] = d[i];
      p++;
    end
    if (PE[g] != 0) begin
      b[p] = ($countones(m) % 2 == 1) ^ (PO[g] != 0);
      p++;
    end
    for (int s = 0; s < SB[g]; s++) begin
      b[p] = 1'b1;
      p++;
    end
    n = p;
    return b;
  endfunction
  task automatic send(input int g, input logic [7:0] d, input bit b2b);
    int n;
    eb[g][wr[g] % 8] = model(g, d, n);
    en[g][wr[g] % 8] = n;
    eb2b[g][wr[g] % 8] = b2b;
    wr[g]++;
    start_s[g] = 1'b1;
    din_s[g] = d;
    @(posedge clk);
    #1;
    start_s[g] = 1'b0;
    din_s[g] = 8'($urandom);
  endtask
  task automatic finish_frame(input int f, input int gap);
    repeat (f + gap) @(posedge clk);
    #1;
  endtask
  task automatic run(input int g);
    int f;
    int gap;
    bit bb;
    f = C * (1 + DB[g] + PE[g] + SB[g]);
    rst_s[g] = 1'b0;
    start_s[g] = 1'b1;
    din_s[g] = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    rst_s[g] = 1'b1;
    start_s[g] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    send(g, g == 0 ? 8'hA5 : 8'h07, 1'b0);
    finish_frame(f, 2);
    send(g, 8'h3C, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    start_s[g] = 1'b1;
    din_s[g] = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    start_s[g] = 1'b0;
    din_s[g] = 8'h81;
    finish_frame(f - 13, 3);
    send(g, 8'($urandom), 1'b0);
    finish_frame(f, 0);
    send(g, 8'($urandom), 1'b1);
    finish_frame(f, 2);
    bb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      gap = $urandom_range(0, 3);
      send(g, 8'($urandom), bb);
      finish_frame(f, gap);
      bb = gap == 0;
    end
    send(g, 8'($urandom), bb);
    repeat (17) @(posedge clk);
    #1;
    rst_s[g] = 1'b0;
    #1;
    check("async_reset", g, {tx_w[g], busy_w[g], done_w[g]}, 3'b100);
    repeat (2) @(posedge clk);
    #1;
    rst_s[g] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(g, 8'($urandom), 1'b0);
    finish_frame(f, 3);
  endtask
  for (genvar g = 0; g < NI; g++) begin : gm
    int phase, cyc, n, sd;
    logic [15:0] bits;
    bit okb, okz, b2b;
    uart_tx_frame #(
      .CLKS_PER_BIT(C),
      .DBIT(DB[g]),
      .PARITY_EN(PE[g]),
      .PARITY_ODD(PO[g]),
      .STOP_BITS(SB[g])
    ) dut (
      .clk(clk),
      .reset(rst_s[g]),
      .tx_start(start_s[g]),
      .din(din_s[g][DB[g]-1:0]),
      .tx_busy(busy_w[g]),
      .tx_done_tick(done_w[g]),
      .tx(tx_w[g])
    );
    initial begin
      phase = 0;
      sd = 100;
      forever begin
        @(negedge clk);
        if (rst_s[g] !== 1'b1) begin
          check("reset_out", g, {tx_w[g], busy_w[g], done_w[g]}, 3'b100);
          phase = 0;
          sd = 100;
        end else if (phase == 2) begin
          check("done_end", g, {tx_w[g], busy_w[g], done_w[g]}, 3'b101);
          check("frame_bits", g, okb, 1);
          check("busy_in_frame", g, okz, 1);
          phase = 0;
          sd = 0;
        end else begin
          if (phase == 0) begin
            sd++;
            if (tx_w[g] === 1'b0) begin
              if (rd[g] == wr[g]) begin
                check("unexpected_frame", g, 1, 0);
                bits = '0;
                n = 1 + DB[g] + PE[g] + SB[g];
              end else begin
                bits = eb[g][rd[g] % 8];
                n = en[g][rd[g] % 8];
                b2b = eb2b[g][rd[g] % 8];
                rd[g]++;
                if (b2b) check("b2b_gap", g, sd, 1);
              end
              phase = 1;
              cyc = 0;
              okb = 1'b1;
              okz = 1'b1;
            end else check("idle_out", g, {busy_w[g], done_w[g]}, 2'b00);
          end
          if (phase == 1) begin
            if (tx_w[g] !== bits[cyc / C]) okb = 1'b0;
            if (busy_w[g] !== 1'b1 || done_w[g] !== 1'b0) okz = 1'b0;
            cyc++;
            if (cyc == n * C) phase = 2;
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    for (int g = 0; g < NI; g++) begin
      wr[g] = 0;
      rd[g] = 0;
    end
    fork
      run(0);
      run(1);
      run(2);
      run(3);
    join
    repeat (4) @(posedge clk);
    for (int g = 0; g < NI; g++) check("drain", g, rd[g], wr[g]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
